// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and default sizes for the countdown timer
package countdown_pkg;

    localparam int CD_WIDTH    = 7;
    localparam int CD_MAX_LOAD = 100;
    localparam int CD_RC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } cd_state_t;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with pause, abort and auto-reload
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = CD_WIDTH,
    parameter int MAX_LOAD = CD_MAX_LOAD,
    parameter int RC_WIDTH = CD_RC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                pause,
    input  logic                abort,
    input  logic                auto_reload,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic [RC_WIDTH-1:0] reload_cnt
);

    localparam logic [WIDTH-1:0]    MAX_W  = WIDTH'(MAX_LOAD);
    localparam logic [WIDTH-1:0]    ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0]    ZERO_W = '0;
    localparam logic [RC_WIDTH-1:0] RC_ONE = RC_WIDTH'(1);

    cd_state_t           state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    cap_q, cap_d;
    logic [RC_WIDTH-1:0] rc_q, rc_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                transfer;
    logic [WIDTH-1:0]    load_sat;

    assign start_ready = (state_q == IDLE);
    assign transfer    = start_valid & start_ready;
    assign load_sat    = (load_val > MAX_W) ? MAX_W : load_val;

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign reload_cnt = rc_q;

    // Next-state logic: start capture in IDLE; abort > pause > decrement > terminal while busy.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cap_d   = cap_q;
        rc_d    = rc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    cap_d   = load_sat;
                    count_d = load_sat;
                    rc_d    = '0;
                    if (load_sat == ZERO_W) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN, HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = ZERO_W;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (count_q > ONE_W) begin
                    count_d = count_q - ONE_W;
                    state_d = RUN;
                end else begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        count_d = cap_q;
                        state_d = RUN;
                        if (rc_q != '1) begin
                            rc_d = rc_q + RC_ONE;
                        end
                    end else begin
                        count_d = ZERO_W;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = ZERO_W;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, count, capture, reload counter and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            cap_q   <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cap_q   <= cap_d;
            rc_q    <= rc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

endmodule
